calc_entry_seq: RTL
===================

Name: calc_entry_seq

Overview:
- Input-side counterpart to the switch-to-display calculator datapath: captures operands and operation sequentially from SW plus pushbuttons, instead of reading them live from the switches.
- Drives registered a0/a1/s into the add_sub ALU and latches the returned result/carry for the display logic.
- Contains a 4-state entry FSM, per-key synchronizer and debouncer, and a result capture register.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a key level change (10 ms at 50 MHz; benches use 4).
- CNT_W, 19, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- CLOCK_50  in   1   system clock, all flops rising edge
- RST       in   1   asynchronous, active-high reset
- SW        in   10  SW[3:0] operand nibble, SW[9] op select (0 add, 1 sub); other bits ignored
- KEY       in   2   raw pushbuttons, active-low; KEY[0] = ENTER, KEY[1] = CLEAR
- a0        out  4   registered operand A to ALU
- a1        out  4   registered operand B to ALU
- s         out  1   registered op select to ALU
- f_in      in   4   ALU result
- cout_in   in   1   ALU carry/borrow out
- result    out  4   latched ALU result
- carry     out  1   latched ALU carry
- stage     out  2   FSM state: 0 ENTER_A, 1 ENTER_B, 2 ENTER_OP, 3 SHOW
- done      out  1   one-cycle pulse when result/carry are latched

Behaviour:
- Reset (async, RST=1): state ENTER_A, a0=a1=0, s=0, result=0, carry=0, done=0, debouncers stable=1 (released), counters 0, synchronizers 1.
- Per key: 2-FF synchronizer, then debouncer.
  - If the synced level differs from the stable level, the counter increments; otherwise the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, stable takes the synced level and the counter clears.
  - Press event = stable 1->0; one cycle wide.
  - Latency from raw edge to press event: 2 sync cycles + DEBOUNCE_CYCLES.
  - Release generates no event. Held key produces exactly one event.
- FSM on ENTER press:
  - ENTER_A: a0<=SW[3:0]; go to ENTER_B.
  - ENTER_B: a1<=SW[3:0]; go to ENTER_OP.
  - ENTER_OP: s<=SW[9]; go to CALC_INT (internal 1-cycle state; stage reports 2 during it).
  - CALC_INT: result<=f_in, carry<=cout_in, done=1 this cycle; go to SHOW unconditionally. ENTER is ignored here.
  - SHOW: on ENTER, go to ENTER_A. Registers are retained until overwritten.
- CLEAR press (any state, including CALC_INT):
  - Next cycle: state ENTER_A, a0=a1=0, s=0, result=0, carry=0.
  - done is not asserted; a CALC_INT latch in that same cycle is suppressed.
- Simultaneous ENTER and CLEAR events in the same cycle: CLEAR wins; ENTER is discarded.
- Outputs a0/a1/s change only on their capture edges. SW changes at any other time have no effect.
- Widths: no arithmetic inside the block; result and carry are copied verbatim from the ALU. Subtraction semantics belong to add_sub.
- RST mid-sequence or mid-debounce: immediate return to the reset values above; a partially counted bounce is discarded.
- Bounce shorter than DEBOUNCE_CYCLES produces no event. Counter saturation cannot occur, because it clears on acceptance.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: assert RST mid-clock -> all outputs 0 and stage=0 immediately, without waiting for a clock edge.
- Add path:
  - SW=0x003, press ENTER; SW=0x005, press; SW[9]=0, press.
  - Expect a0=3, a1=5, s=0 and stage sequence 0,1,2,3.
  - With the ALU model returning f_in=8, cout_in=0: result=8, carry=0, single done pulse.
- Sub path: A=2, B=7, SW[9]=1 -> s=1; latch ALU outputs f_in=0xB, cout_in=0 -> result=0xB, carry=0.
- Bounce: toggle KEY[0] low/high every 2 cycles for 20 cycles, then hold low 10 cycles -> exactly one stage advance, occurring 6 cycles after the final falling edge.
- Hold: keep ENTER low 100 cycles -> one advance only. SW changes while ENTER is held -> a0 unchanged.
- CLEAR:
  - CLEAR in ENTER_OP with a0=9, a1=4 -> next cycle stage=0, a0=a1=0.
  - CLEAR and ENTER events in the same cycle from SHOW -> stage=0, done never asserted.

Source files
------------

// File: rtl/calc_entry_seq.sv
// -----------------------------------------------------------------------------
// calc_entry_seq
//   Sequential operand/operation entry for the switch-driven calculator.
//   The operands and the operation are taken from the switches one at a time,
//   on ENTER presses, instead of being read live. The registered operands and
//   operation go to the external add_sub ALU. The ALU result and carry are
//   latched for the display logic.
//
// Ports
//   CLOCK_50  in   1   system clock; every flop uses the rising edge
//   RST       in   1   asynchronous, active-high reset
//   SW        in  10   SW[3:0] operand nibble, SW[9] op select (0 add, 1 sub)
//   KEY       in   2   raw active-low pushbuttons: KEY[0] ENTER, KEY[1] CLEAR
//   a0        out  4   registered operand A to the ALU
//   a1        out  4   registered operand B to the ALU
//   s         out  1   registered op select to the ALU
//   f_in      in   4   ALU result
//   cout_in   in   1   ALU carry/borrow out
//   result    out  4   latched ALU result
//   carry     out  1   latched ALU carry
//   stage     out  2   entry stage: 0 ENTER_A, 1 ENTER_B, 2 ENTER_OP, 3 SHOW
//   done      out  1   one-cycle pulse in the cycle result/carry show new data
// -----------------------------------------------------------------------------
module calc_entry_seq #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic        CLOCK_50,
    input  logic        RST,
    input  logic [9:0]  SW,
    input  logic [1:0]  KEY,
    output logic [3:0]  a0,
    output logic [3:0]  a1,
    output logic        s,
    input  logic [3:0]  f_in,
    input  logic        cout_in,
    output logic [3:0]  result,
    output logic        carry,
    output logic [1:0]  stage,
    output logic        done
);

    // CALC_INT is internal only. stage reports it as ENTER_OP.
    typedef enum logic [2:0] {
        ST_ENTER_A  = 3'd0,
        ST_ENTER_B  = 3'd1,
        ST_ENTER_OP = 3'd2,
        ST_SHOW     = 3'd3,
        ST_CALC     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Map the internal state onto the externally visible stage code.
    function automatic logic [1:0] stage_of(input state_t st);
        logic [1:0] code;
        case (st)
            ST_ENTER_A:  code = 2'd0;
            ST_ENTER_B:  code = 2'd1;
            ST_ENTER_OP: code = 2'd2;
            ST_CALC:     code = 2'd2;
            ST_SHOW:     code = 2'd3;
            default:     code = 2'd0;
        endcase
        return code;
    endfunction

    logic [1:0]       sync1_r;
    logic [1:0]       sync2_r;
    logic [1:0]       stable_r;
    logic [CNT_W-1:0] cnt_r [2];
    logic [1:0]       press_s;
    logic             enter_s;
    logic             clear_s;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [3:0]       a0_nxt_s;
    logic [3:0]       a1_nxt_s;
    logic             s_nxt_s;
    logic [3:0]       result_nxt_s;
    logic             carry_nxt_s;
    logic             done_nxt_s;

    // SW[8:4] are not used by this block.
    logic             unused_sw_s;
    assign unused_sw_s = ^SW[8:4];

    // Key synchronizers and debouncers. Idle (released) keys read 1.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            sync1_r  <= 2'b11;
            sync2_r  <= 2'b11;
            stable_r <= 2'b11;
            for (int k = 0; k < 2; k++) begin
                cnt_r[k] <= '0;
            end
        end else begin
            sync1_r <= KEY;
            sync2_r <= sync1_r;
            for (int k = 0; k < 2; k++) begin
                if (sync2_r[k] != stable_r[k]) begin
                    if (cnt_r[k] == CNT_LAST) begin
                        stable_r[k] <= sync2_r[k];
                        cnt_r[k]    <= '0;
                    end else begin
                        cnt_r[k]    <= cnt_r[k] + CNT_ONE;
                    end
                end else begin
                    cnt_r[k] <= '0;
                end
            end
        end
    end

    // A press event is the cycle in which a key's stable level is about to
    // fall. The FSM therefore acts on the same edge that the debouncer accepts.
    always_comb begin
        press_s = 2'b00;
        for (int k = 0; k < 2; k++) begin
            press_s[k] = stable_r[k] & ~sync2_r[k] & (cnt_r[k] == CNT_LAST);
        end
    end

    // CLEAR takes priority over a coincident ENTER.
    assign clear_s = press_s[1];
    assign enter_s = press_s[0] & ~press_s[1];

    // Entry FSM: next state and next values of the captured registers.
    always_comb begin
        state_nxt_s  = state_r;
        a0_nxt_s     = a0;
        a1_nxt_s     = a1;
        s_nxt_s      = s;
        result_nxt_s = result;
        carry_nxt_s  = carry;
        done_nxt_s   = 1'b0;
        if (clear_s) begin
            // CLEAR also pre-empts the CALC_INT latch.
            state_nxt_s  = ST_ENTER_A;
            a0_nxt_s     = 4'd0;
            a1_nxt_s     = 4'd0;
            s_nxt_s      = 1'b0;
            result_nxt_s = 4'd0;
            carry_nxt_s  = 1'b0;
        end else begin
            case (state_r)
                ST_ENTER_A: begin
                    if (enter_s) begin
                        a0_nxt_s    = SW[3:0];
                        state_nxt_s = ST_ENTER_B;
                    end else begin
                        state_nxt_s = ST_ENTER_A;
                    end
                end
                ST_ENTER_B: begin
                    if (enter_s) begin
                        a1_nxt_s    = SW[3:0];
                        state_nxt_s = ST_ENTER_OP;
                    end else begin
                        state_nxt_s = ST_ENTER_B;
                    end
                end
                ST_ENTER_OP: begin
                    if (enter_s) begin
                        s_nxt_s     = SW[9];
                        state_nxt_s = ST_CALC;
                    end else begin
                        state_nxt_s = ST_ENTER_OP;
                    end
                end
                ST_CALC: begin
                    // The ALU has had one cycle to settle on the new s.
                    result_nxt_s = f_in;
                    carry_nxt_s  = cout_in;
                    done_nxt_s   = 1'b1;
                    state_nxt_s  = ST_SHOW;
                end
                ST_SHOW: begin
                    if (enter_s) begin
                        state_nxt_s = ST_ENTER_A;
                    end else begin
                        state_nxt_s = ST_SHOW;
                    end
                end
                default: begin
                    state_nxt_s = ST_ENTER_A;
                end
            endcase
        end
    end

    // State register and all registered outputs.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            state_r <= ST_ENTER_A;
            a0      <= 4'd0;
            a1      <= 4'd0;
            s       <= 1'b0;
            result  <= 4'd0;
            carry   <= 1'b0;
            done    <= 1'b0;
            stage   <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            a0      <= a0_nxt_s;
            a1      <= a1_nxt_s;
            s       <= s_nxt_s;
            result  <= result_nxt_s;
            carry   <= carry_nxt_s;
            done    <= done_nxt_s;
            stage   <= stage_of(state_nxt_s);
        end
    end

endmodule
